// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding
// and master identifiers.
package bus_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ACCESS = 2'd1;
    localparam state_t S_RESP   = 2'd2;

    localparam logic M_FETCH = 1'b0;
    localparam logic M_LSU   = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a sole requester wins, and on a tie the master
// that was not granted last time wins.
module rr_pick2
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Priority select from the request pair and the last-owner bit.
    always_comb begin
        valid = |req;
        grant = M_FETCH;
        if (req[0] && req[1]) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = M_LSU;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (fetch / load-store) arbiter onto a single-cycle downstream bus.
// One access per three cycles: IDLE picks and latches, ACCESS drives the
// bus and captures the response, RESP returns it to the owner.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; on any request latch the winner and move to ACCESS
// ACCESS | acs_en=1 for one cycle, response captured at the cycle end
// RESP   | owner gets its one-cycle ack with the captured rdata/error
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [XLEN/8-1:0] m0_bytes,
    input  logic [XLEN-1:0]   m0_addr,
    input  logic [XLEN-1:0]   m0_wdata,
    output logic              m0_ack,
    output logic [XLEN-1:0]   m0_rdata,
    output logic              m0_error,

    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [XLEN/8-1:0] m1_bytes,
    input  logic [XLEN-1:0]   m1_addr,
    input  logic [XLEN-1:0]   m1_wdata,
    output logic              m1_ack,
    output logic [XLEN-1:0]   m1_rdata,
    output logic              m1_error,

    output logic              acs_en,
    output logic              acs_wr,
    output logic [XLEN/8-1:0] acs_bytes,
    output logic [XLEN-1:0]   acs_addr,
    output logic [XLEN-1:0]   acs_wdata,
    input  logic [XLEN-1:0]   acs_rdata,
    input  logic              acs_error
);

    localparam int BW = XLEN / 8;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_owner;
    logic              pick;
    logic              pick_valid;
    logic              start;
    logic              in_access;
    logic              in_resp;

    logic              lat_wr;
    logic [BW-1:0]     lat_bytes;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_error;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_owner),
        .grant (pick),
        .valid (pick_valid)
    );

    assign start     = (state == S_IDLE) && pick_valid;
    assign in_access = (state == S_ACCESS);
    assign in_resp   = (state == S_RESP);

    // Next-state logic; ACCESS and RESP always advance regardless of requests.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pick_valid) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner and last-owner only move on a grant; reset favours master 0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= M_FETCH;
            last_owner <= M_LSU;
        end else if (start) begin
            owner      <= pick;
            last_owner <= pick;
        end
    end

    // Capture the winner's request so later req/field changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr    <= 1'b0;
            lat_bytes <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (start) begin
            lat_wr    <= (pick == M_LSU) ? m1_wr    : m0_wr;
            lat_bytes <= (pick == M_LSU) ? m1_bytes : m0_bytes;
            lat_addr  <= (pick == M_LSU) ? m1_addr  : m0_addr;
            lat_wdata <= (pick == M_LSU) ? m1_wdata : m0_wdata;
        end
    end

    // Register the downstream response at the end of the ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (in_access) begin
            rsp_rdata <= acs_rdata;
            rsp_error <= acs_error;
        end
    end

    // Downstream drive, gated to ACCESS so the bus is quiet otherwise.
    always_comb begin
        acs_en    = in_access;
        acs_wr    = in_access & lat_wr;
        acs_bytes = in_access ? lat_bytes : '0;
        acs_addr  = in_access ? lat_addr  : '0;
        acs_wdata = in_access ? lat_wdata : '0;
    end

    // Responses go only to the owner and only during RESP; read data is not
    // filtered on writes.
    always_comb begin
        m0_ack   = in_resp && (owner == M_FETCH);
        m1_ack   = in_resp && (owner == M_LSU);
        m0_rdata = m0_ack ? rsp_rdata : '0;
        m1_rdata = m1_ack ? rsp_rdata : '0;
        m0_error = m0_ack & rsp_error;
        m1_error = m1_ack & rsp_error;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed per-cycle vector table,
// hand-written reset/idle sequences, then randomized traffic against a
// cycle-arithmetic reference model of the arbitration rules.
module tb_bus_arbiter;

    localparam int XLEN = 32;
    localparam int BW   = XLEN / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mreq;
    logic [1:0]      mwr;
    logic [BW-1:0]   mbytes [2];
    logic [XLEN-1:0] maddr  [2];
    logic [XLEN-1:0] mwdata [2];
    logic            m0_ack, m1_ack, m0_error, m1_error;
    logic [XLEN-1:0] m0_rdata, m1_rdata;
    logic            acs_en, acs_wr;
    logic [BW-1:0]   acs_bytes;
    logic [XLEN-1:0] acs_addr, acs_wdata;
    logic [XLEN-1:0] acs_rdata;
    logic            acs_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (mreq[0]),
        .m0_wr     (mwr[0]),
        .m0_bytes  (mbytes[0]),
        .m0_addr   (maddr[0]),
        .m0_wdata  (mwdata[0]),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_error  (m0_error),
        .m1_req    (mreq[1]),
        .m1_wr     (mwr[1]),
        .m1_bytes  (mbytes[1]),
        .m1_addr   (maddr[1]),
        .m1_wdata  (mwdata[1]),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_error  (m1_error),
        .acs_en    (acs_en),
        .acs_wr    (acs_wr),
        .acs_bytes (acs_bytes),
        .acs_addr  (acs_addr),
        .acs_wdata (acs_wdata),
        .acs_rdata (acs_rdata),
        .acs_error (acs_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic [31:0] srd;
        logic        serr;
        logic        en;
        logic [31:0] addr;
        logic        wr;
        logic        a0;
        logic        a1;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    function automatic vec_t mk(logic rs, logic r0, logic r1, logic [31:0] srd, logic serr,
                                logic en, logic [31:0] addr, logic wr,
                                logic a0, logic a1, logic [31:0] rd, logic er);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.r1 = r1; v.srd = srd; v.serr = serr;
        v.en = en; v.addr = addr; v.wr = wr; v.a0 = a0; v.a1 = a1; v.rd = rd; v.er = er;
        return v;
    endfunction

    localparam logic [31:0] A0 = 32'h8000_0010;
    localparam logic [31:0] A1 = 32'hA000_0000;
    localparam logic [31:0] WD1 = 32'hDEAD_BEEF;

    vec_t tv [29];

    // reference model state for the random phase
    logic            last_m, w, exp_en, ack_own, ack_er, ea0, ea1;
    int              free_at, ack_cyc;
    int              hold_until [2];
    int              drop_at    [2];
    logic [XLEN-1:0] ack_rd;
    logic [1:0]      p_req, p_wr;
    logic [BW-1:0]   p_bytes [2];
    logic [XLEN-1:0] p_addr  [2];
    logic [XLEN-1:0] p_wdata [2];

    initial begin
        // rst  r0 r1 srd           serr en addr wr a0 a1 rd            er
        tv[0]  = mk(0, 1, 0, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[1]  = mk(0, 1, 0, 32'h1234_5678,  0, 1, A0, 0, 0, 0, 32'h0,          0);
        tv[2]  = mk(0, 1, 0, 32'h0,          0, 0, 0,  0, 1, 0, 32'h1234_5678,  0);
        tv[3]  = mk(0, 0, 0, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[4]  = mk(0, 0, 1, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[5]  = mk(0, 0, 1, 32'hAAAA_5555,  1, 1, A1, 1, 0, 0, 32'h0,          0);
        tv[6]  = mk(0, 0, 1, 32'h0,          0, 0, 0,  0, 0, 1, 32'hAAAA_5555,  1);
        tv[7]  = mk(0, 0, 0, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[8]  = mk(0, 1, 0, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[9]  = mk(0, 1, 1, 32'h1111_0000,  0, 1, A0, 0, 0, 0, 32'h0,          0);
        tv[10] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 1, 0, 32'h1111_0000,  0);
        tv[11] = mk(0, 0, 1, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[12] = mk(0, 0, 1, 32'h2222_0000,  0, 1, A1, 1, 0, 0, 32'h0,          0);
        tv[13] = mk(0, 0, 1, 32'h0,          0, 0, 0,  0, 0, 1, 32'h2222_0000,  0);
        tv[14] = mk(0, 0, 0, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[15] = mk(1, 1, 1, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[16] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[17] = mk(0, 1, 1, 32'h30,         0, 1, A0, 0, 0, 0, 32'h0,          0);
        tv[18] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 1, 0, 32'h30,         0);
        tv[19] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[20] = mk(0, 1, 1, 32'h31,         0, 1, A1, 1, 0, 0, 32'h0,          0);
        tv[21] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 0, 1, 32'h31,         0);
        tv[22] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[23] = mk(0, 1, 1, 32'h32,         0, 1, A0, 0, 0, 0, 32'h0,          0);
        tv[24] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 1, 0, 32'h32,         0);
        tv[25] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);
        tv[26] = mk(0, 1, 1, 32'h33,         0, 1, A1, 1, 0, 0, 32'h0,          0);
        tv[27] = mk(0, 1, 1, 32'h0,          0, 0, 0,  0, 0, 1, 32'h33,         0);
        tv[28] = mk(0, 0, 0, 32'h0,          0, 0, 0,  0, 0, 0, 32'h0,          0);

        // reset with both masters requesting: everything must stay quiet
        rst = 1'b1;
        mreq = 2'b11;
        mwr = 2'b10;
        mbytes[0] = 4'hF; maddr[0] = A0; mwdata[0] = 32'h0BAD_F00D;
        mbytes[1] = 4'hF; maddr[1] = A1; mwdata[1] = WD1;
        acs_rdata = 32'h5555_AAAA;
        acs_error = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_en",    acs_en, 0);
            check("rst_acks",  {m0_ack, m1_ack}, 0);
            check("rst_wr",    {acs_wr, acs_bytes}, 0);
            check("rst_rdata", {m0_rdata, m1_rdata, m0_error, m1_error}, 0);
        end
        mreq = 2'b00;
        acs_error = 1'b0;
        rst = 1'b0;

        // directed vector table: single read, write with error, late request, tie
        foreach (tv[i]) begin
            @(posedge clk); #1;
            rst = tv[i].rst;
            mreq = {tv[i].r1, tv[i].r0};
            acs_rdata = tv[i].srd;
            acs_error = tv[i].serr;
            #1;
            check($sformatf("vec%0d_en", i), acs_en, tv[i].en);
            check($sformatf("vec%0d_wr", i), acs_wr, tv[i].wr);
            if (tv[i].en) begin
                check($sformatf("vec%0d_addr", i), acs_addr, tv[i].addr);
                check($sformatf("vec%0d_bytes", i), acs_bytes, 4'hF);
                if (tv[i].wr)
                    check($sformatf("vec%0d_wdata", i), acs_wdata, WD1);
            end else begin
                check($sformatf("vec%0d_bytes", i), acs_bytes, 0);
            end
            check($sformatf("vec%0d_ack0", i), m0_ack, tv[i].a0);
            check($sformatf("vec%0d_ack1", i), m1_ack, tv[i].a1);
            check($sformatf("vec%0d_rd0", i), m0_rdata, tv[i].a0 ? tv[i].rd : 32'h0);
            check($sformatf("vec%0d_er0", i), m0_error, tv[i].a0 & tv[i].er);
            check($sformatf("vec%0d_rd1", i), m1_rdata, tv[i].a1 ? tv[i].rd : 32'h0);
            check($sformatf("vec%0d_er1", i), m1_error, tv[i].a1 & tv[i].er);
        end

        // reset pulsed during ACCESS: bus drops at once, no ack, next tie goes to m0
        @(posedge clk); #1;
        mreq = 2'b10;
        @(posedge clk); #1;
        check("abort_en_before", acs_en, 1);
        rst = 1'b1;
        #1;
        check("abort_en_now", acs_en, 0);
        check("abort_acks_now", {m0_ack, m1_ack}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mreq = 2'b00;
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_no_ack", {acs_en, m0_ack, m1_ack}, 0);
        end
        mreq = 2'b11;
        @(posedge clk); #1;
        check("abort_tie_en", acs_en, 1);
        check("abort_tie_addr", acs_addr, A0);
        mreq = 2'b00;
        @(posedge clk); #1;
        check("abort_tie_ack", {m0_ack, m1_ack}, 2'b10);
        @(posedge clk); #1;
        check("drop_no_grant", acs_en, 0);

        // idle hold
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("idle%0d", c), {acs_en, m0_ack, m1_ack}, 0);
        end

        // randomized traffic against the reference model
        rst = 1'b1;
        mreq = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_m = 1'b1;
        free_at = 0;
        ack_cyc = -1;
        ack_own = 1'b0;
        ack_rd = '0;
        ack_er = 1'b0;
        w = 1'b0;
        for (int m = 0; m < 2; m++) begin
            hold_until[m] = -1;
            drop_at[m] = -1;
            p_bytes[m] = mbytes[m];
            p_addr[m] = maddr[m];
            p_wdata[m] = mwdata[m];
        end
        p_req = mreq;
        p_wr = mwr;

        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk); #1;
            exp_en = 1'b0;
            if (k - 1 >= free_at && p_req != 2'b00) begin
                w = (p_req == 2'b11) ? ~last_m : p_req[1];
                exp_en = 1'b1;
                last_m = w;
                free_at = k + 2;
                ack_cyc = k + 1;
                ack_own = w;
                hold_until[w] = k + 1;
                drop_at[w] = k + 2;
            end
            acs_rdata = $urandom;
            acs_error = 1'($urandom_range(0, 1));
            if (exp_en) begin
                ack_rd = acs_rdata;
                ack_er = acs_error;
            end
            #1;
            check("rnd_en", acs_en, exp_en);
            if (exp_en) begin
                check("rnd_wr",    acs_wr,    p_wr[w]);
                check("rnd_bytes", acs_bytes, p_bytes[w]);
                check("rnd_addr",  acs_addr,  p_addr[w]);
                check("rnd_wdata", acs_wdata, p_wdata[w]);
            end else begin
                check("rnd_idle_wr", {acs_wr, acs_bytes}, 0);
            end
            ea0 = (k == ack_cyc) && (ack_own == 1'b0);
            ea1 = (k == ack_cyc) && (ack_own == 1'b1);
            check("rnd_ack0", m0_ack, ea0);
            check("rnd_ack1", m1_ack, ea1);
            check("rnd_rd0",  m0_rdata, ea0 ? ack_rd : '0);
            check("rnd_rd1",  m1_rdata, ea1 ? ack_rd : '0);
            check("rnd_er0",  m0_error, ea0 & ack_er);
            check("rnd_er1",  m1_error, ea1 & ack_er);

            for (int m = 0; m < 2; m++) begin
                if (k <= hold_until[m]) begin
                    // owner keeps its request steady until its ack
                end else if (k == drop_at[m]) begin
                    mreq[m] = 1'b0;
                end else begin
                    mreq[m] = ($urandom_range(0, 2) != 0);
                    mwr[m] = 1'($urandom_range(0, 1));
                    mbytes[m] = 4'($urandom_range(0, 15));
                    maddr[m] = $urandom;
                    mwdata[m] = $urandom;
                end
                p_bytes[m] = mbytes[m];
                p_addr[m] = maddr[m];
                p_wdata[m] = mwdata[m];
            end
            p_req = mreq;
            p_wr = mwr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
